syndrome_horner: RTL



---
 rtl/bch_pkg.sv | 28 ++
 rtl/pb_mult_new.sv | 32 +++
 rtl/syndrome_horner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// ---------------------------------------------------------------------------
// bch_pkg
// Shared constants and types for the GF(2^13) BCH decoder datapath.
//   M        : field degree (13)
//   GF_POLY  : low terms of the field polynomial x^13 + x^4 + x^3 + x + 1
//   ONE      : multiplicative identity in polynomial-basis form
//   horner_state_t : state encoding of the serial syndrome evaluator
// ---------------------------------------------------------------------------
package bch_pkg;

    localparam int          M       = 13;
    localparam logic [12:0] GF_POLY = 13'h001B;
    localparam logic [12:0] ONE     = 13'h0001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } horner_state_t;

    // Multiply a field element by x and reduce. The bit shifted out of the
    // top stands for x^13, which folds back in as GF_POLY.
    function automatic logic [12:0] gf_xtime(input logic [12:0] v);
        return {v[11:0], 1'b0} ^ (v[12] ? GF_POLY : 13'h0000);
    endfunction

endpackage

// File: rtl/pb_mult_new.sv
// ---------------------------------------------------------------------------
// pb_mult_new
// Combinational polynomial-basis multiplier over GF(2^13), reduced modulo
// x^13 + x^4 + x^3 + x + 1.
//   a : M-bit multiplicand (PB form)
//   b : M-bit multiplier   (PB form)
//   p : M-bit product a*b  (PB form)
// ---------------------------------------------------------------------------
module pb_mult_new #(
    parameter int M = bch_pkg::M
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);
    import bch_pkg::*;

    // MSB-first shift-and-add: each step multiplies the partial product by x
    // (with reduction) and then conditionally adds a.
    always_comb begin
        logic [M-1:0] t;
        t = '0;
        for (int i = M - 1; i >= 0; i--) begin
            t = gf_xtime(t);
            if (b[i]) begin
                t = t ^ a;
            end
        end
        p = t;
    end

endmodule

// File: rtl/syndrome_horner.sv
// ---------------------------------------------------------------------------
// syndrome_horner
// Serial syndrome evaluator: computes r(alpha^j) = sum r_i * alpha^(j*i) by
// Horner's rule, one received bit per cycle, highest-order coefficient first.
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset
//   start        : single-cycle request to begin an evaluation (IDLE only)
//   alpha_in     : evaluation point, PB form (from exponent.b)
//   alpha_valid  : alpha_in valid (from exponent.done), used in WAIT_A only
//   r_bit        : received codeword bit
//   r_valid      : r_bit valid this cycle
//   r_ready      : block accepts r_bit this cycle (high only in ACCUM)
//   syn          : syndrome result, PB form, held until the next DONE
//   done         : one-cycle pulse, syn carries the new value in that cycle
//
// Handshake: a bit transfers on a rising edge where r_valid and r_ready are
// both high; r_ready never depends on r_valid, and with r_valid low all
// accumulator and counter state holds unchanged.
//
// The internal signal `state` (horner_state_t) is the FSM state and is the
// intended hook for checkers.
// ---------------------------------------------------------------------------
module syndrome_horner #(
    parameter int M  = bch_pkg::M,
    parameter int N  = 8191,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] alpha_in,
    input  logic         alpha_valid,
    input  logic         r_bit,
    input  logic         r_valid,
    output logic         r_ready,
    output logic [M-1:0] syn,
    output logic         done
);
    import bch_pkg::*;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    horner_state_t state;
    horner_state_t state_nx;

    logic [M-1:0]  acc;
    logic [M-1:0]  alpha_r;
    logic [CW-1:0] cnt;
    logic [M-1:0]  prod;
    logic [M-1:0]  acc_nx;
    logic          xfer;
    logic          last_xfer;

    // Single multiplier in the feedback loop; this is the critical path and
    // cannot be pipelined without breaking the one-bit-per-cycle recurrence.
    pb_mult_new #(
        .M (M)
    ) u_mult (
        .a (acc),
        .b (alpha_r),
        .p (prod)
    );

    assign acc_nx    = prod ^ {{(M-1){1'b0}}, r_bit};
    assign r_ready   = (state == ACCUM);
    assign done      = (state == DONE);
    assign xfer      = r_valid & r_ready;
    assign last_xfer = xfer && (cnt == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. alpha_valid is only looked at in WAIT_A, so an
    // alpha_valid coincident with start is deliberately dropped; start is
    // only looked at in IDLE, so a start held through DONE is not re-armed
    // until the FSM is back in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WAIT_A;
                end
            end
            WAIT_A: begin
                if (alpha_valid) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (last_xfer) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: accumulator, latched evaluation point, bit counter, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            alpha_r <= '0;
            cnt     <= '0;
            syn     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                WAIT_A: begin
                    if (alpha_valid) begin
                        alpha_r <= alpha_in;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc <= acc_nx;
                        cnt <= cnt + CW'(1);
                        // syn takes the value including the final bit r_0,
                        // so it is already valid in the DONE cycle.
                        if (last_xfer) begin
                            syn <= acc_nx;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
